// File: rtl/ast_width_reducer.sv
// ast_width_reducer
// Avalon-ST width reducer. Each accepted wide beat (DATA_IN_W) is held and
// replayed as a sequence of narrow beats (DATA_OUT_W), first symbol in the
// MSBs. Packet framing (sop/eop), channel and empty are carried through.
//
// Ports
//   clk_i                rising-edge clock
//   srst_i               synchronous reset, active-high
//   ast_*_i (wide side)  data/startofpacket/endofpacket/valid/empty/channel in
//   ast_ready_o          the block accepts a wide beat this cycle
//   ast_*_o (narrow)     data/startofpacket/endofpacket/valid/empty/channel out
//   ast_ready_i          the sink accepts the narrow beat (ready latency 0)
module ast_width_reducer #(
    parameter int DATA_IN_W   = 64,
    parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int K         = DATA_IN_W / DATA_OUT_W;
    localparam int BYTES_IN  = DATA_IN_W / 8;
    localparam int BYTES_OUT = DATA_OUT_W / 8;
    localparam int IDX_W     = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Valid bytes of a wide beat; empty only counts on the eop beat.
    function automatic int valid_bytes(input logic eop, input logic [EMPTY_IN_W-1:0] empty);
        int vb_v;
        if (eop) begin
            vb_v = BYTES_IN - int'(empty);
        end else begin
            vb_v = BYTES_IN;
        end
        return vb_v;
    endfunction

    // Index of the last narrow slice needed to carry vb bytes.
    function automatic logic [IDX_W-1:0] calc_last_idx(input int vb);
        return IDX_W'((vb + BYTES_OUT - 1) / BYTES_OUT - 1);
    endfunction

    // Unused bytes in the final narrow slice carrying vb bytes.
    function automatic logic [EMPTY_OUT_W-1:0] calc_slice_empty(input int vb);
        return EMPTY_OUT_W'((BYTES_OUT - (vb % BYTES_OUT)) % BYTES_OUT);
    endfunction

    state_t                 state_r;
    logic [DATA_IN_W-1:0]   data_r;        // shifted left one slice per transfer
    logic                   held_eop_r;
    logic [CHANNEL_W-1:0]   channel_r;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       last_idx_r;
    logic [EMPTY_OUT_W-1:0] eop_empty_r;   // empty to present on the eop slice
    logic                   sop_o_r;
    logic                   eop_o_r;
    logic [EMPTY_OUT_W-1:0] empty_o_r;

    int                     in_vb_s;
    logic [IDX_W-1:0]       in_last_idx_s;
    logic [EMPTY_OUT_W-1:0] in_empty_s;
    logic                   in_eop_first_s;
    logic                   at_last_s;
    logic                   ready_s;
    logic                   in_xfer_s;
    logic                   out_xfer_s;
    logic [IDX_W-1:0]       next_idx_s;
    logic                   next_is_eop_s;

    // Handshake decode and slice bookkeeping for the incoming and held beat.
    always_comb begin
        in_vb_s        = valid_bytes(ast_endofpacket_i, ast_empty_i);
        in_last_idx_s  = calc_last_idx(in_vb_s);
        in_empty_s     = calc_slice_empty(in_vb_s);
        in_eop_first_s = ast_endofpacket_i && (in_last_idx_s == '0);
        at_last_s      = (state_r == ST_SEND) && (idx_r == last_idx_r);
        // A new beat can enter only when the held one is finished this cycle.
        ready_s        = !srst_i && ((state_r == ST_IDLE) || (at_last_s && ast_ready_i));
        in_xfer_s      = ast_valid_i && ready_s;
        out_xfer_s     = (state_r == ST_SEND) && ast_ready_i;
        next_idx_s     = idx_r + IDX_W'(1);
        next_is_eop_s  = held_eop_r && (next_idx_s == last_idx_r);
    end

    // Slicing FSM: load a wide beat, then step through its slices.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            held_eop_r  <= 1'b0;
            channel_r   <= '0;
            idx_r       <= '0;
            last_idx_r  <= '0;
            eop_empty_r <= '0;
            sop_o_r     <= 1'b0;
            eop_o_r     <= 1'b0;
            empty_o_r   <= '0;
        end else if (in_xfer_s) begin
            // Covers both the idle load and the load on the last transfer.
            state_r     <= ST_SEND;
            data_r      <= ast_data_i;
            held_eop_r  <= ast_endofpacket_i;
            channel_r   <= ast_channel_i;
            idx_r       <= '0;
            last_idx_r  <= in_last_idx_s;
            eop_empty_r <= in_empty_s;
            sop_o_r     <= ast_startofpacket_i;
            eop_o_r     <= in_eop_first_s;
            empty_o_r   <= in_eop_first_s ? in_empty_s : {EMPTY_OUT_W{1'b0}};
        end else if (out_xfer_s) begin
            if (at_last_s) begin
                state_r   <= ST_IDLE;
                idx_r     <= '0;
                sop_o_r   <= 1'b0;
                eop_o_r   <= 1'b0;
                empty_o_r <= '0;
            end else begin
                idx_r     <= next_idx_s;
                data_r    <= data_r << DATA_OUT_W;
                sop_o_r   <= 1'b0;
                eop_o_r   <= next_is_eop_s;
                empty_o_r <= next_is_eop_s ? eop_empty_r : {EMPTY_OUT_W{1'b0}};
            end
        end
    end

    // Outputs come from registers; reset forces them low in the reset cycle too.
    assign ast_ready_o         = ready_s;
    assign ast_valid_o         = !srst_i && (state_r == ST_SEND);
    assign ast_data_o          = srst_i ? {DATA_OUT_W{1'b0}} : data_r[DATA_IN_W-1 -: DATA_OUT_W];
    assign ast_startofpacket_o = !srst_i && sop_o_r;
    assign ast_endofpacket_o   = !srst_i && eop_o_r;
    assign ast_empty_o         = srst_i ? {EMPTY_OUT_W{1'b0}} : empty_o_r;
    assign ast_channel_o       = srst_i ? {CHANNEL_W{1'b0}} : channel_r;

endmodule

// File: doc/ast_width_reducer.md
# ast_width_reducer

Avalon-ST width reducer: accepts wide beats (DATA_IN_W) and emits each as a sequence of narrow beats (DATA_OUT_W), preserving packet framing, channel and empty semantics. It is the counterpart of ast_width_extender. It sits directly downstream of the extender in the loopback datapath, so wide packets are returned to the original narrow width. It can also be used standalone wherever a wide stream must feed a narrow sink.

## Interface

Parameters:
- DATA_IN_W, 64, input data width in bits; multiple of 8 and of DATA_OUT_W.
- EMPTY_IN_W, $clog2(DATA_IN_W/8), input empty width.
- CHANNEL_W, 10, channel width.
- DATA_OUT_W, 16, output data width in bits; multiple of 8; K = DATA_IN_W/DATA_OUT_W ≥ 2.
- EMPTY_OUT_W, $clog2(DATA_OUT_W/8) (minimum 1), output empty width.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- srst_i  in  1  synchronous reset, active-high.
- ast_data_i  in  DATA_IN_W  wide beat data; the first symbol is in the MSBs.
- ast_startofpacket_i  in  1  first beat of packet.
- ast_endofpacket_i  in  1  last beat of packet.
- ast_valid_i  in  1  input beat valid.
- ast_empty_i  in  EMPTY_IN_W  unused bytes at the LSB end; meaningful only with eop.
- ast_channel_i  in  CHANNEL_W  channel of the beat.
- ast_ready_o  out  1  block can accept an input beat this cycle.
- ast_data_o  out  DATA_OUT_W  narrow beat data.
- ast_startofpacket_o  out  1  first narrow beat of packet.
- ast_endofpacket_o  out  1  last narrow beat of packet.
- ast_valid_o  out  1  output beat valid.
- ast_empty_o  out  EMPTY_OUT_W  unused bytes in the last narrow beat.
- ast_channel_o  out  CHANNEL_W  channel copied from the source wide beat.
- ast_ready_i  in  1  sink accepts the output beat.

## Operation

- **Input handshake:** a beat is accepted when ast_valid_i && ast_ready_o. The accepted beat is stored in a holding register together with its sop, eop, empty and channel.
- **States:**
  - IDLE: holding register empty.
  - SEND: slicing the held beat; slice index idx runs 0..last_idx.
- **Slice count:**
  - Non-eop beat: last_idx = K-1.
  - Eop beat: vb = DATA_IN_W/8 - ast_empty_i valid bytes; last_idx = ceil(vb / (DATA_OUT_W/8)) - 1.
  - ast_empty_i on non-eop beats is ignored and treated as 0.
- **Slice data:** slice idx = held_data[DATA_IN_W-1-idx*DATA_OUT_W -: DATA_OUT_W].
- **Output flags:**
  - ast_startofpacket_o = held_sop && idx==0.
  - ast_endofpacket_o = held_eop && idx==last_idx.
  - ast_empty_o = 0 except on the eop slice, where it is (DATA_OUT_W/8 - vb mod (DATA_OUT_W/8)) mod (DATA_OUT_W/8).
  - Unused trailing bytes of the eop slice carry the held data unchanged; the sink must not check them.
  - ast_channel_o = held channel for every slice.
- **Advance:** on each output transfer (ast_valid_o && ast_ready_i), idx increments.
- **Last slice:** when the last slice transfers, the FSM loads the next wide beat if one is accepted that same cycle (idx=0, stay SEND); otherwise it goes to IDLE.
- **Ready:** ast_ready_o = !srst_i && (state==IDLE || (idx==last_idx && ast_ready_i)).
- **No protocol checking:** sop/eop errors are passed through unchanged (missing eop, sop without a preceding eop).

## Timing

- **Reset:** srst_i high clears state to IDLE, idx=0, and drives all outputs to 0. This includes ast_ready_o=0 during reset and ast_valid_o=0. ast_ready_o goes high on the first cycle after reset deasserts.
- **Latency:** a wide beat accepted at edge N appears as slice 0 on the outputs after edge N (registered outputs, 1 cycle).
- **Throughput:** with ast_ready_i constantly 1, back-to-back wide beats produce continuous narrow output with no bubbles. That is K output cycles per full beat, and last_idx+1 cycles for an eop beat.
- **Backpressure:** ast_ready_i is ready-latency 0. While ast_valid_o=1 && ast_ready_i=0, all outputs hold stable. ast_valid_o never drops without a transfer.
- **Simultaneous load and last transfer:** this is a single-cycle event; no beat is duplicated or lost.
- **Reset mid-packet:** the held beat and any remaining slices are discarded. No eop is emitted.

## Test plan

Parameters for all scenarios: DATA_IN_W=64, DATA_OUT_W=16 (K=4), CHANNEL_W=10.

1. **Full single-beat packet.** One beat, sop=eop=1, empty=0, data 64'h0011_2233_4455_6677, ready_i=1 → slices 16'h0011, 16'h2233, 16'h4455, 16'h6677. sop on slice 0 only, eop on slice 3 only, empty_o=0 on all.
2. **Partial eop beat.** Eop beat with empty_i=3, data 64'h0011_2233_44xx_xxxx → 3 slices 16'h0011, 16'h2233, 16'h44xx. eop and empty_o=1 on the third; ready_o returns high after the third transfer.
3. **One-slice packet.** sop+eop beat with empty_i=6 → exactly one slice, carrying both sop and eop, with empty_o=0.
4. **Back-to-back multi-beat packet.** 3-beat packet on channel 10'h2A, valid_i held high, ready_i=1 → 12 consecutive valid slices with no gaps. channel_o=10'h2A on all, sop on slice 0, eop on slice 11. ready_o high only on cycles 3, 7 and 11 of the stream.
5. **Random backpressure.** Random ready_i (50%) → output stalls with data/flags stable while ready_i=0. Scoreboard byte stream equals the input stream minus empty bytes, in order.
6. **Reset mid-packet.** srst_i pulsed for 1 cycle after slice 1 of a 4-slice beat → valid_o=0 and ready_o=0 in the reset cycle, and no further slices of that beat are emitted. A subsequent packet is passed correctly.
